// File: rtl/regfile_wb_arbiter.sv
// Register-file write-port owner: round-robin arbitration among writeback requesters,
// plus a clear sequence that zeroes x1..x31 after reset or on request.
module regfile_wb_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned XLEN = 32,
  parameter int unsigned AW   = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*AW-1:0]   req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  output logic [NREQ-1:0]      req_ready,
  input  logic                 clear_req,
  output logic                 reg_write,
  output logic [AW-1:0]        rd,
  output logic [XLEN-1:0]      write_data,
  output logic                 init_done
);

  localparam int unsigned PW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int          NReq = int'(NREQ);

  typedef enum logic [0:0] {StClear, StRun} state_e;

  state_e          state_q, state_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            reg_write_q, reg_write_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] write_data_q, write_data_d;

  logic [AW-1:0]   rd_arr   [NREQ];
  logic [XLEN-1:0] data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign rd_arr[i]   = req_rd[i*AW +: AW];
    assign data_arr[i] = req_data[i*XLEN +: XLEN];
  end

  logic          gnt_found;
  logic [PW-1:0] gnt_idx;
  logic [PW-1:0] scan_idx;
  int            ptr_base;

  // Round-robin scan starting at rr_ptr; the pointer is reduced modulo NREQ first.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    ptr_base  = int'(rr_ptr_q) % NReq;
    for (int k = 0; k < NReq; k++) begin
      scan_idx = PW'((ptr_base + k) % NReq);
      if (!gnt_found && req_valid[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rr_ptr_d     = rr_ptr_q;
    reg_write_d  = 1'b0;
    rd_d         = rd_q;
    write_data_d = write_data_q;
    req_ready    = '0;

    unique case (state_q)
      StClear: begin
        reg_write_d  = 1'b1;
        rd_d         = cnt_q;
        write_data_d = '0;
        if (cnt_q == '1) begin
          state_d = StRun;
          cnt_d   = AW'(1);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (clear_req) begin
          // Clear wins over any pending request; nothing is granted this cycle.
          state_d = StClear;
          cnt_d   = AW'(1);
        end else if (gnt_found) begin
          req_ready[gnt_idx] = 1'b1;
          reg_write_d        = (rd_arr[gnt_idx] != '0);
          rd_d               = rd_arr[gnt_idx];
          write_data_d       = data_arr[gnt_idx];
          rr_ptr_d           = (gnt_idx == PW'(NReq - 1)) ? '0 : gnt_idx + 1'b1;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StClear;
      cnt_q        <= AW'(1);
      rr_ptr_q     <= '0;
      reg_write_q  <= 1'b0;
      rd_q         <= '0;
      write_data_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rr_ptr_q     <= rr_ptr_d;
      reg_write_q  <= reg_write_d;
      rd_q         <= rd_d;
      write_data_q <= write_data_d;
    end
  end

  assign reg_write  = reg_write_q;
  assign rd         = rd_q;
  assign write_data = write_data_q;
  assign init_done  = (state_q == StRun);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Scoreboard bench for regfile_wb_arbiter: a cycle model predicts grants and pushes
// expected register-file writes, which are popped when the DUT presents them.
module tb_regfile_wb_arbiter;

  localparam int NREQ = 3;
  localparam int XLEN = 32;
  localparam int AW   = 5;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*AW-1:0]   req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic [NREQ-1:0]      req_ready;
  logic                 clear_req;
  logic                 reg_write;
  logic [AW-1:0]        rd;
  logic [XLEN-1:0]      write_data;
  logic                 init_done;

  logic [AW-1:0]   rd_v   [NREQ];
  logic [XLEN-1:0] data_v [NREQ];

  always_comb begin
    req_rd   = '0;
    req_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_rd[i*AW +: AW]       = rd_v[i];
      req_data[i*XLEN +: XLEN] = data_v[i];
    end
  end

  regfile_wb_arbiter #(.NREQ(NREQ), .XLEN(XLEN), .AW(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_rd     (req_rd),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .clear_req  (clear_req),
    .reg_write  (reg_write),
    .rd         (rd),
    .write_data (write_data),
    .init_done  (init_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  logic [AW+XLEN-1:0] sb[$];
  bit m_run = 1'b0;
  bit m_rw  = 1'b0;
  int m_cnt = 1;
  int m_ptr = 0;

  // Reference model, evaluated mid-cycle with inputs stable.
  always @(negedge clk) begin
    int g;
    logic [AW+XLEN-1:0] e;
    logic [NREQ-1:0] exp_ready;
    check_eq("init_done", init_done, m_run);
    check_eq("reg_write", reg_write, m_rw);
    if (reg_write === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_write", reg_write, 1'b0);
      end else begin
        e = sb.pop_front();
        check_eq("rd", rd, e[AW+XLEN-1:XLEN]);
        check_eq("write_data", write_data, e[XLEN-1:0]);
      end
    end
    g = -1;
    if (m_run && !clear_req) begin
      for (int k = 0; k < NREQ; k++) begin
        if (g < 0 && req_valid[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
      end
    end
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check_eq("req_ready", req_ready, exp_ready);

    if (reset) begin
      m_run = 1'b0; m_cnt = 1; m_ptr = 0; m_rw = 1'b0;
      sb.delete();
    end else if (!m_run) begin
      m_rw = 1'b1;
      sb.push_back({AW'(m_cnt), {XLEN{1'b0}}});
      if (m_cnt == 31) begin
        m_run = 1'b1;
        m_cnt = 1;
      end else begin
        m_cnt++;
      end
    end else if (clear_req) begin
      m_run = 1'b0; m_cnt = 1; m_rw = 1'b0;
    end else if (g >= 0) begin
      m_rw  = (rd_v[g] != '0);
      if (m_rw) sb.push_back({rd_v[g], data_v[g]});
      m_ptr = (g + 1) % NREQ;
    end else begin
      m_rw = 1'b0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_run();
    bit seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (init_done === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    check_eq("init_timeout", seen, 1'b1);
  endtask

  initial begin
    reset     = 1'b1;
    clear_req = 1'b0;
    rd_v[0] = 5'd5; data_v[0] = 32'hAAAA_0001;
    rd_v[1] = 5'd6; data_v[1] = 32'hBBBB_0002;
    rd_v[2] = 5'd7; data_v[2] = 32'hCCCC_0003;
    req_valid = 3'b001;  // must stay ungranted throughout the clear
    repeat (2) cyc();
    reset = 1'b0;
    wait_run();

    req_valid = 3'b111;
    repeat (6) cyc();
    req_valid = 3'b000;
    cyc();

    rd_v[1] = 5'd9; data_v[1] = 32'h1234_5678;
    req_valid = 3'b010;
    repeat (4) cyc();

    rd_v[2] = 5'd0; data_v[2] = 32'hDEAD_BEEF;
    req_valid = 3'b100;
    cyc();
    rd_v[2] = 5'd7; data_v[2] = 32'hCCCC_0003;
    req_valid = 3'b111;
    repeat (3) cyc();

    clear_req = 1'b1;
    req_valid = 3'b001;
    cyc();
    clear_req = 1'b0;
    repeat (5) cyc();
    clear_req = 1'b1;  // ignored while clearing
    cyc();
    clear_req = 1'b0;
    wait_run();
    cyc();
    req_valid = 3'b000;
    cyc();

    clear_req = 1'b1;
    cyc();
    clear_req = 1'b0;
    repeat (11) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    wait_run();
    repeat (3) cyc();

    check_eq("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
